// File: rtl/slice_sequencer_if.sv
// slice_sequencer_if
//   Handshake bundle for the slice sequencer: an upstream word channel
//   (in_valid / in_ready / data_in) and a downstream slice channel
//   (out_valid / out_ready / data_out / slice_index / last).
//   slave  : the sequencer itself.
//   master : the environment that feeds words and consumes slices.
interface slice_sequencer_if #(
    parameter int INPUT_DATA_WIDTH = 32,
    parameter int SLICE_WIDTH      = 8
);
    localparam int N     = INPUT_DATA_WIDTH / SLICE_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic                        in_valid;
    logic                        in_ready;
    logic [INPUT_DATA_WIDTH-1:0] data_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [SLICE_WIDTH-1:0]      data_out;
    logic [IDX_W-1:0]            slice_index;
    logic                        last;

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, slice_index, last
    );

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, slice_index, last
    );
endinterface

// File: rtl/slice_sequencer.sv
// slice_sequencer
//   Accepts a word of INPUT_DATA_WIDTH bits and emits it as N slices of
//   SLICE_WIDTH bits, MSB slice first (MSB_FIRST=1) or LSB slice first.
//   A new word may be accepted on the same edge that the final slice of the
//   previous word is taken, so back-to-back words stream without a bubble.
// Ports
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   flush : synchronous abort of the word in progress (highest priority)
//   busy  : high whenever the FSM is not in IDLE
//   s     : handshake bundle (slave side)
//
//   state | meaning
//   ------+------------------------------------------
//   IDLE  | no word held, out_valid low
//   EMIT  | word held, slice slice_index on data_out
module slice_sequencer #(
    parameter int INPUT_DATA_WIDTH = 32,
    parameter int SLICE_WIDTH      = 8,
    parameter bit MSB_FIRST        = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    output logic                  busy,
    slice_sequencer_if.slave      s
);
    localparam int N     = INPUT_DATA_WIDTH / SLICE_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if ((INPUT_DATA_WIDTH % SLICE_WIDTH) != 0 || N < 2) begin : g_bad_params
        $error("slice_sequencer: INPUT_DATA_WIDTH must be a multiple (>=2x) of SLICE_WIDTH");
    end

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                      state_q, state_nxt;
    logic [INPUT_DATA_WIDTH-1:0] hold_q, hold_nxt;
    logic [SLICE_WIDTH-1:0]      dout_q, dout_nxt;
    logic [IDX_W-1:0]            idx_q, idx_nxt;
    logic                        valid_q, valid_nxt;

    logic last_w;
    logic in_fire;
    logic out_fire;

    function automatic logic [SLICE_WIDTH-1:0] slice_of(
        input logic [INPUT_DATA_WIDTH-1:0] w,
        input logic [IDX_W-1:0]            k
    );
        if (MSB_FIRST)
            return w[INPUT_DATA_WIDTH-1-int'(k)*SLICE_WIDTH -: SLICE_WIDTH];
        else
            return w[int'(k)*SLICE_WIDTH +: SLICE_WIDTH];
    endfunction

    assign last_w   = valid_q && (idx_q == IDX_W'(N-1));
    assign out_fire = valid_q && s.out_ready;
    // rst gates in_ready so nothing is offered while the block is held in reset.
    assign s.in_ready = !rst && !flush && ((state_q == IDLE) || (out_fire && last_w));
    assign in_fire  = s.in_valid && s.in_ready;

    assign s.out_valid   = valid_q;
    assign s.data_out    = dout_q;
    assign s.slice_index = idx_q;
    assign s.last        = last_w;
    assign busy          = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            dout_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            hold_q  <= hold_nxt;
            dout_q  <= dout_nxt;
            idx_q   <= idx_nxt;
            valid_q <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        hold_nxt  = hold_q;
        dout_nxt  = dout_q;
        idx_nxt   = idx_q;
        valid_nxt = valid_q;
        if (flush) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            idx_nxt   = '0;
        end else if (in_fire) begin
            // Covers both a fresh start from IDLE and the seamless hand-over
            // when the last slice of the previous word leaves on this edge.
            state_nxt = EMIT;
            hold_nxt  = s.data_in;
            dout_nxt  = slice_of(s.data_in, '0);
            idx_nxt   = '0;
            valid_nxt = 1'b1;
        end else if (out_fire) begin
            if (last_w) begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
                idx_nxt   = '0;
            end else begin
                idx_nxt  = idx_q + IDX_W'(1);
                dout_nxt = slice_of(hold_q, idx_q + IDX_W'(1));
            end
        end
    end
endmodule

// File: tb/tb_slice_sequencer.sv
module tb_slice_sequencer;
    localparam int IW = 32;
    localparam int SW = 8;
    localparam int N  = IW / SW;

    logic clk;
    logic rst;
    logic flush;
    logic busy_m, busy_l;

    int n_tests = 0;
    int n_fail  = 0;

    slice_sequencer_if #(.INPUT_DATA_WIDTH(IW), .SLICE_WIDTH(SW)) if_m ();
    slice_sequencer_if #(.INPUT_DATA_WIDTH(IW), .SLICE_WIDTH(SW)) if_l ();

    slice_sequencer #(.INPUT_DATA_WIDTH(IW), .SLICE_WIDTH(SW), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy_m), .s(if_m.slave));
    slice_sequencer #(.INPUT_DATA_WIDTH(IW), .SLICE_WIDTH(SW), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .flush(flush), .busy(busy_l), .s(if_l.slave));

    // index 0 = MSB-first instance, index 1 = LSB-first instance
    logic          ov[2];
    logic [SW-1:0] dout[2];
    logic [1:0]    idx[2];
    logic          lst[2];
    logic          bsy[2];
    logic          ir[2];
    assign ov[0] = if_m.out_valid;   assign ov[1] = if_l.out_valid;
    assign dout[0] = if_m.data_out;  assign dout[1] = if_l.data_out;
    assign idx[0] = if_m.slice_index; assign idx[1] = if_l.slice_index;
    assign lst[0] = if_m.last;       assign lst[1] = if_l.last;
    assign bsy[0] = busy_m;          assign bsy[1] = busy_l;
    assign ir[0] = if_m.in_ready;    assign ir[1] = if_l.in_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference: slice k of word w in emission order, by shift-and-mask.
    function automatic logic [SW-1:0] exp_slice(input logic [IW-1:0] w, input int k, input bit msb);
        int pos;
        pos = msb ? (N - 1 - k) : k;
        return SW'((w >> (pos * SW)) & 32'hFF);
    endfunction

    task automatic drive(input logic v, input logic [IW-1:0] d, input logic r, input logic f);
        if_m.in_valid = v;  if_l.in_valid = v;
        if_m.data_in = d;   if_l.data_in = d;
        if_m.out_ready = r; if_l.out_ready = r;
        flush = f;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        #3;
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({ov[u], dout[u], idx[u], lst[u], bsy[u], ir[u]} !== 14'b0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got ov=%b dout=%h idx=%0d last=%b busy=%b in_ready=%b required all 0",
                         u, ov[u], dout[u], idx[u], lst[u], bsy[u], ir[u]);
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({ov[u], bsy[u], ir[u]} !== 3'b001) begin
                n_fail++;
                $display("FAIL post_reset_idle[%0d]: got ov=%b busy=%b in_ready=%b required 0 0 1",
                         u, ov[u], bsy[u], ir[u]);
            end
        end
    endtask

    task automatic test_basic();
        logic [IW-1:0] w;
        logic [SW-1:0] em[4];
        logic [SW-1:0] el[4];
        w = 32'hA1B2C3D4;
        em = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        el = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        drive(1'b1, w, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            for (int u = 0; u < 2; u++) begin
                logic [SW-1:0] e;
                e = (u == 0) ? em[k] : el[k];
                n_tests++;
                if ({ov[u], dout[u], idx[u], lst[u]} !== {1'b1, e, 2'(k), (k == 3)}) begin
                    n_fail++;
                    $display("FAIL basic_slice[%0d] k=%0d: got ov=%b dout=%h idx=%0d last=%b required 1 %h %0d %b",
                             u, k, ov[u], dout[u], idx[u], lst[u], e, k, (k == 3));
                end
            end
            @(posedge clk); #1;
        end
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({ov[u], bsy[u]} !== 2'b00) begin
                n_fail++;
                $display("FAIL basic_end_idle[%0d]: got ov=%b busy=%b required 0 0", u, ov[u], bsy[u]);
            end
        end
    endtask

    task automatic test_stall();
        logic [IW-1:0] w;
        w = 32'hA1B2C3D4;
        drive(1'b1, w, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            for (int u = 0; u < 2; u++) begin
                n_tests++;
                if ({ov[u], dout[u], idx[u], lst[u]} !== {1'b1, exp_slice(w, 1, u == 0), 2'd1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL stall_hold[%0d] c=%0d: got ov=%b dout=%h idx=%0d last=%b required 1 %h 1 0",
                             u, c, ov[u], dout[u], idx[u], lst[u], exp_slice(w, 1, u == 0));
                end
            end
            if (c < 3) begin
                @(posedge clk); #1;
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({ov[u], dout[u], idx[u]} !== {1'b1, exp_slice(w, 2, u == 0), 2'd2}) begin
                n_fail++;
                $display("FAIL stall_resume[%0d]: got ov=%b dout=%h idx=%0d required 1 %h 2",
                         u, ov[u], dout[u], idx[u], exp_slice(w, 2, u == 0));
            end
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] w[2];
        w = '{32'h11223344, 32'h55667788};
        drive(1'b1, w[0], 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, w[1], 1'b1, 1'b0);
        for (int k = 0; k < 2 * N; k++) begin
            for (int u = 0; u < 2; u++) begin
                logic [SW-1:0] e;
                e = exp_slice(w[k / N], k % N, u == 0);
                n_tests++;
                if ({ov[u], dout[u], idx[u]} !== {1'b1, e, 2'(k % N)}) begin
                    n_fail++;
                    $display("FAIL b2b_slice[%0d] k=%0d: got ov=%b dout=%h idx=%0d required 1 %h %0d",
                             u, k, ov[u], dout[u], idx[u], e, k % N);
                end
                if (k == N - 1) begin
                    n_tests++;
                    if (ir[u] !== 1'b1) begin
                        n_fail++;
                        $display("FAIL b2b_in_ready[%0d]: got %b required 1", u, ir[u]);
                    end
                end
            end
            if (k == N) drive(1'b0, '0, 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if (ov[u] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_end_idle[%0d]: got ov=%b required 0", u, ov[u]);
            end
        end
    endtask

    task automatic test_flush();
        logic [IW-1:0] w, w2;
        w  = 32'hDEADBEEF;
        w2 = 32'h0BADF00D;
        drive(1'b1, w, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, w2, 1'b1, 1'b1);
        #1;
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({idx[u], ir[u]} !== {2'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL flush_gate[%0d]: got idx=%0d in_ready=%b required 1 0", u, idx[u], ir[u]);
            end
        end
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({ov[u], bsy[u], idx[u]} !== 4'b0) begin
                n_fail++;
                $display("FAIL flush_idle[%0d]: got ov=%b busy=%b idx=%0d required 0 0 0", u, ov[u], bsy[u], idx[u]);
            end
        end
        drive(1'b1, w2, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({ov[u], dout[u], idx[u]} !== {1'b1, exp_slice(w2, 0, u == 0), 2'd0}) begin
                n_fail++;
                $display("FAIL flush_restart[%0d]: got ov=%b dout=%h idx=%0d required 1 %h 0",
                         u, ov[u], dout[u], idx[u], exp_slice(w2, 0, u == 0));
            end
        end
        repeat (N) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        logic [IW-1:0] w;
        w = 32'hCAFE1234;
        drive(1'b1, w, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({ov[u], dout[u], idx[u], lst[u], bsy[u], ir[u]} !== 14'b0) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: got ov=%b dout=%h idx=%0d last=%b busy=%b in_ready=%b required all 0",
                         u, ov[u], dout[u], idx[u], lst[u], bsy[u], ir[u]);
            end
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int c = 0; c < N + 1; c++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                n_tests++;
                if (ov[u] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL async_reset_no_leftover[%0d] c=%0d: got ov=%b dout=%h required ov 0",
                             u, c, ov[u], dout[u]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [IW-1:0] q[$];
        int pos;
        logic v, r, f, exp_last, exp_ir, in_fire, out_fire;
        logic [IW-1:0] d;
        pos = 0;
        for (int c = 0; c < 500; c++) begin
            for (int u = 0; u < 2; u++) begin
                n_tests++;
                if (q.size() == 0) begin
                    if (ov[u] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL rand_valid[%0d] c=%0d: got ov=%b required 0", u, c, ov[u]);
                    end
                end else if ({ov[u], dout[u], idx[u], lst[u]} !==
                             {1'b1, exp_slice(q[0], pos, u == 0), 2'(pos), (pos == N - 1)}) begin
                    n_fail++;
                    $display("FAIL rand_slice[%0d] c=%0d: got ov=%b dout=%h idx=%0d last=%b required 1 %h %0d %b",
                             u, c, ov[u], dout[u], idx[u], lst[u], exp_slice(q[0], pos, u == 0), pos, (pos == N - 1));
                end
            end
            v = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 19) == 0);
            d = $urandom;
            drive(v, d, r, f);
            #1;
            exp_last = (q.size() != 0) && (pos == N - 1);
            exp_ir   = !f && ((q.size() == 0) || (r && exp_last));
            for (int u = 0; u < 2; u++) begin
                n_tests++;
                if (ir[u] !== exp_ir) begin
                    n_fail++;
                    $display("FAIL rand_in_ready[%0d] c=%0d: got %b required %b", u, c, ir[u], exp_ir);
                end
            end
            in_fire  = v && exp_ir;
            out_fire = (q.size() != 0) && r;
            @(posedge clk);
            if (out_fire) begin
                if (pos == N - 1) begin
                    void'(q.pop_front());
                    pos = 0;
                end else begin
                    pos++;
                end
            end
            if (f) begin
                q.delete();
                pos = 0;
            end
            if (in_fire) q.push_back(d);
            #1;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        repeat (N + 1) begin
            @(posedge clk); #1;
        end
        for (int u = 0; u < 2; u++) begin
            n_tests++;
            if ({ov[u], bsy[u]} !== 2'b00) begin
                n_fail++;
                $display("FAIL rand_drain[%0d]: got ov=%b busy=%b required 0 0", u, ov[u], bsy[u]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/slice_sequencer.md
SLICE_SEQUENCER -- requirements
Module: slice_sequencer

Interface
REQ-001 The block SHALL have parameter INPUT_DATA_WIDTH, default 32, giving the width of the accepted word.
REQ-002 The block SHALL have parameter SLICE_WIDTH, default 8, giving the width of each emitted slice; INPUT_DATA_WIDTH SHALL be an integer multiple of SLICE_WIDTH, and N = INPUT_DATA_WIDTH/SLICE_WIDTH SHALL be at least 2.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1: 1 emits the most-significant slice first, 0 emits the least-significant slice first.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, an asynchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit, a synchronous abort of the word in progress.
REQ-007 The block SHALL have port in_valid, input, 1 bit, indicating that data_in holds a word.
REQ-008 The block SHALL have port in_ready, output, 1 bit, indicating that the block accepts a word this cycle.
REQ-009 The block SHALL have port data_in, input, INPUT_DATA_WIDTH bits, the word to be sliced.
REQ-010 The block SHALL have port out_valid, output, 1 bit, indicating that data_out holds a slice.
REQ-011 The block SHALL have port out_ready, input, 1 bit, the downstream accept.
REQ-012 The block SHALL have port data_out, output, SLICE_WIDTH bits, the current slice, driven from a register.
REQ-013 The block SHALL have port slice_index, output, ceil(log2(N)) bits, the emission position of the current slice (0..N-1).
REQ-014 The block SHALL have port last, output, 1 bit, high with the final slice of a word.
REQ-015 The block SHALL have port busy, output, 1 bit, high whenever the block is not in IDLE.

Function
REQ-016 The block SHALL implement two states: IDLE (no word held) and EMIT (word held, slices pending).
REQ-017 A transfer SHALL occur on an input when in_valid and in_ready are both high at a rising clk edge, and on an output when out_valid and out_ready are both high at a rising clk edge.
REQ-018 in_ready SHALL be high when (state==IDLE or (out_valid and out_ready and last)) and flush is low; it SHALL be combinational from these terms only.
REQ-019 An input transfer SHALL capture data_in into a holding register, set slice_index to 0, load data_out with slice 0, set out_valid to 1, and enter EMIT on the same edge (one-cycle latency from input transfer to first out_valid).
REQ-020 For MSB_FIRST=1, slice k SHALL be data_in[INPUT_DATA_WIDTH-1-k*SLICE_WIDTH -: SLICE_WIDTH]; for MSB_FIRST=0, slice k SHALL be data_in[k*SLICE_WIDTH +: SLICE_WIDTH].
REQ-021 While out_valid is high and out_ready is low, data_out, slice_index and last SHALL hold unchanged.
REQ-022 An output transfer with last low SHALL advance slice_index by 1 and load the next slice on that edge.
REQ-023 last SHALL be high exactly when out_valid is high and slice_index == N-1.
REQ-024 An output transfer with last high and no simultaneous input transfer SHALL clear out_valid and return to IDLE.
REQ-025 An output transfer with last high and a simultaneous input transfer SHALL stay in EMIT and present slice 0 of the new word on the next cycle, with no bubble.
REQ-026 flush high at a rising edge SHALL clear out_valid, clear slice_index, and enter IDLE regardless of state or out_ready; it SHALL take priority over every other event, and no input transfer SHALL occur in that cycle.
REQ-027 A slice SHALL never be emitted twice or skipped: each accepted, unflushed word SHALL produce exactly N output transfers in order.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, force state to IDLE, out_valid=0, last=0, busy=0, slice_index=0, data_out=0, and clear the holding register.
REQ-029 While rst is high, in_ready SHALL be 0; on the first rising edge after rst deasserts, the block SHALL be in IDLE and in_ready SHALL follow REQ-018.
REQ-030 Reset asserted mid-word SHALL discard the remaining slices, and no slice of that word SHALL appear after reset.

Verification
REQ-031 Defaults, data_in=0xA1B2C3D4, out_ready held 1 -> out_valid on 4 consecutive cycles with data_out A1,B2,C3,D4, slice_index 0..3, and last only on D4.
REQ-032 MSB_FIRST=0, same word -> D4,C3,B2,A1 in that order.
REQ-033 out_ready low for 3 cycles while slice B2 is shown -> B2/slice_index=1 held stable for those cycles, then C3 follows.
REQ-034 Words 0x11223344 and 0x55667788 offered back-to-back with out_ready=1 -> 8 consecutive valid slices 11..88 with no idle cycle, and in_ready high on the cycle of the 44 transfer.
REQ-035 flush pulsed while slice index 1 is shown -> out_valid low next cycle and busy=0; a following word starts at slice_index 0.
REQ-036 rst asserted asynchronously mid-word -> outputs zero before the next clk edge, and no remaining slices appear after release.
